// File: rtl/r2sdf_bf_stage_if.sv
// Sample stream bundle for one R2SDF FFT stage: input sample, frame start,
// and the registered output sample with its bit-reversed position.
interface r2sdf_bf_stage_if #(
  parameter int N = 3,
  parameter int W = 16
);
  logic                start_ip;
  logic signed [W-1:0] ip_re;
  logic signed [W-1:0] ip_im;
  logic signed [W-1:0] op_re;
  logic signed [W-1:0] op_im;
  logic                start_op;
  logic [N-1:0]        op_idx;

  modport master (
    output start_ip, ip_re, ip_im,
    input  op_re, op_im, start_op, op_idx
  );

  modport slave (
    input  start_ip, ip_re, ip_im,
    output op_re, op_im, start_op, op_idx
  );
endinterface

// File: rtl/r2sdf_bf_stage.sv
// One radix-2 single-path delay-feedback DIF FFT stage: feedback delay of
// D = 2^(N-S), butterfly with 1/2 scaling, twiddle rotation of the differences.
module r2sdf_bf_stage #(
  parameter int N  = 3,
  parameter int S  = 1,
  parameter int W  = 16,
  parameter int TW = 16
) (
  input logic            clk,
  input logic            rst,
  r2sdf_bf_stage_if.slave bus
);

  localparam int D  = 1 << (N - S);
  localparam int L  = 1 << N;
  localparam int CW = N - S + 1;
  localparam int PW = W + TW + 1;

  localparam logic signed [PW-1:0] SMAX = {{(TW + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(TW + 2){1'b1}}, {(W - 1){1'b0}}};
  localparam logic signed [PW-1:0] RND  = PW'(1) << (TW - 2);

  function automatic logic signed [TW-1:0] tw_coef(input int m, input bit want_sin);
    real ang;
    real v;
    ang = 2.0 * 3.141592653589793 * real'(m) / real'(L);
    v   = (want_sin ? $sin(ang) : $cos(ang)) * (2.0 ** (TW - 1) - 1.0);
    return TW'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SMAX)      return W'(SMAX);
    else if (v < SMIN) return W'(SMIN);
    else               return W'(v);
  endfunction

  logic [CW-1:0]          c_q;
  logic [CW-1:0]          c_cur;
  logic                   fill;
  logic [D-1:0][W-1:0]    dl_re;
  logic [D-1:0][W-1:0]    dl_im;
  logic [D-1:0]           ssr;
  logic signed [W-1:0]    head_re;
  logic signed [W-1:0]    head_im;
  logic signed [W-1:0]    rot_re;
  logic signed [W-1:0]    rot_im;
  logic signed [W:0]      sum_re;
  logic signed [W:0]      sum_im;
  logic signed [W:0]      diff_re;
  logic signed [W:0]      diff_im;
  logic signed [W-1:0]    push_re;
  logic signed [W-1:0]    push_im;
  logic signed [W-1:0]    nxt_re;
  logic signed [W-1:0]    nxt_im;
  logic signed [W-1:0]    op_re_q;
  logic signed [W-1:0]    op_im_q;
  logic                   start_op_q;
  logic [N-1:0]           p_q;
  logic [N-1:0]           idx;

  // start_ip restarts the phase on the very sample that carries it
  assign c_cur   = bus.start_ip ? '0 : c_q;
  assign fill    = ~c_cur[CW-1];
  assign head_re = dl_re[D-1];
  assign head_im = dl_im[D-1];

  assign sum_re  = {head_re[W-1], head_re} + {bus.ip_re[W-1], bus.ip_re};
  assign sum_im  = {head_im[W-1], head_im} + {bus.ip_im[W-1], bus.ip_im};
  assign diff_re = {head_re[W-1], head_re} - {bus.ip_re[W-1], bus.ip_re};
  assign diff_im = {head_im[W-1], head_im} - {bus.ip_im[W-1], bus.ip_im};

  generate
    if (S < N) begin : g_rot
      localparam int MW = N - 1;
      logic signed [TW-1:0] cos_rom [L/2];
      logic signed [TW-1:0] sin_rom [L/2];
      logic [MW-1:0]        m;
      logic signed [PW-1:0] hre_x, him_x, c_x, s_x, acc_re, acc_im;

      for (genvar g = 0; g < L/2; g++) begin : g_rom
        assign cos_rom[g] = tw_coef(g, 1'b0);
        assign sin_rom[g] = tw_coef(g, 1'b1);
      end

      assign m      = MW'(c_cur[CW-2:0]) << (S - 1);
      assign hre_x  = PW'(head_re);
      assign him_x  = PW'(head_im);
      assign c_x    = PW'(cos_rom[m]);
      assign s_x    = PW'(sin_rom[m]);
      assign acc_re = hre_x * c_x + him_x * s_x + RND;
      assign acc_im = him_x * c_x - hre_x * s_x + RND;
      assign rot_re = sat(acc_re >>> (TW - 1));
      assign rot_im = sat(acc_im >>> (TW - 1));
    end else begin : g_bypass
      assign rot_re = head_re;
      assign rot_im = head_im;
    end
  endgenerate

  always_comb begin
    nxt_re  = W'(sum_re >>> 1);
    nxt_im  = W'(sum_im >>> 1);
    push_re = W'(diff_re >>> 1);
    push_im = W'(diff_im >>> 1);
    if (fill) begin
      nxt_re  = rot_re;
      nxt_im  = rot_im;
      push_re = bus.ip_re;
      push_im = bus.ip_im;
    end
  end

  // Shifts are done by concatenating the new entry below and truncating the
  // oldest off the top; this stays valid for D = 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q        <= '0;
      dl_re      <= '0;
      dl_im      <= '0;
      ssr        <= '0;
      op_re_q    <= '0;
      op_im_q    <= '0;
      start_op_q <= '0;
      p_q        <= '0;
    end else begin
      c_q        <= c_cur + CW'(1);
      dl_re      <= (D * W)'({dl_re, push_re});
      dl_im      <= (D * W)'({dl_im, push_im});
      ssr        <= D'({ssr, bus.start_ip});
      op_re_q    <= nxt_re;
      op_im_q    <= nxt_im;
      start_op_q <= ssr[D-1];
      p_q        <= ssr[D-1] ? '0 : p_q + N'(1);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_brev
    assign idx[g] = p_q[N-1-g];
  end

  assign bus.op_re    = op_re_q;
  assign bus.op_im    = op_im_q;
  assign bus.start_op = start_op_q;
  assign bus.op_idx   = idx;

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Directed bench for r2sdf_bf_stage: a first stage (N=3,S=1) and a last
// stage (N=3,S=3) driven from hand-computed vectors.
module tb_r2sdf_bf_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  r2sdf_bf_stage_if #(.N(3), .W(16)) bus1 ();
  r2sdf_bf_stage_if #(.N(3), .W(16)) bus3 ();

  r2sdf_bf_stage #(.N(3), .S(1), .W(16), .TW(16)) u_s1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  r2sdf_bf_stage #(.N(3), .S(3), .W(16), .TW(16)) u_s3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int checks   = 0;
  int failures = 0;
  int idx_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic st, input int re, input int im);
    bus1.start_ip = st;
    bus1.ip_re    = 16'(re);
    bus1.ip_im    = 16'(im);
  endtask

  task automatic drv3(input logic st, input int re, input int im);
    bus3.start_ip = st;
    bus3.ip_re    = 16'(re);
    bus3.ip_im    = 16'(im);
  endtask

  // A zero frame leaves the S=1 delay line all zero
  task automatic flush1();
    drv1(1'b1, 0, 0);
    tick();
    for (int k = 0; k < 7; k++) begin
      drv1(1'b0, 0, 0);
      tick();
    end
  endtask

  task automatic chk_s1(input string t, input int j, input int st, input int re, input int im);
    chk($sformatf("%s start_op j%0d", t, j), int'(bus1.start_op), st);
    chk($sformatf("%s re j%0d", t, j), int'(bus1.op_re), re);
    chk($sformatf("%s im j%0d", t, j), int'(bus1.op_im), im);
  endtask

  initial begin
    int ere, eim;
    drv1(1'b0, 0, 0);
    drv3(1'b0, 0, 0);

    // Reset with random inputs, start_ip asserted in the last reset cycle
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drv1(k == 1 ? 1'b1 : 1'($urandom), int'($urandom), int'($urandom));
      drv3(k == 1 ? 1'b1 : 1'($urandom), int'($urandom), 0);
      tick();
      chk($sformatf("rst s1 re k%0d", k), int'(bus1.op_re), 0);
      chk($sformatf("rst s1 im k%0d", k), int'(bus1.op_im), 0);
      chk($sformatf("rst s1 start k%0d", k), int'(bus1.start_op), 0);
      chk($sformatf("rst s1 idx k%0d", k), int'(bus1.op_idx), 0);
      chk($sformatf("rst s3 re k%0d", k), int'(bus3.op_re), 0);
      chk($sformatf("rst s3 start k%0d", k), int'(bus3.start_op), 0);
      chk($sformatf("rst s3 idx k%0d", k), int'(bus3.op_idx), 0);
    end
    rst = 1'b0;
    drv1(1'b0, 0, 0);
    drv3(1'b0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_s1("post_rst", k, 0, 0, 0);
      chk($sformatf("post_rst s3 start k%0d", k), int'(bus3.start_op), 0);
    end

    // Impulse at x[0], then a back-to-back zero frame at j=8
    for (int j = 0; j < 20; j++) begin
      drv1(j == 0 || j == 8, j == 0 ? 1000 : 0, 0);
      tick();
      chk_s1("impulse", j, (j == 4 || j == 12) ? 1 : 0, (j == 4 || j == 8) ? 500 : 0, 0);
      if (j >= 4) chk($sformatf("impulse idx j%0d", j), int'(bus1.op_idx), idx_tab[(j - 4) % 8]);
    end

    // Impulse at x[1]: position 1 = 500, position 5 = 354 - j354
    flush1();
    for (int j = 0; j < 16; j++) begin
      drv1(j == 0 || j == 8, j == 1 ? 1000 : 0, 0);
      tick();
      ere = (j == 5) ? 500 : (j == 9) ? 354 : 0;
      eim = (j == 9) ? -354 : 0;
      chk_s1("twiddle", j, (j == 4 || j == 12) ? 1 : 0, ere, eim);
    end

    // Constant 100 over three back-to-back frames
    flush1();
    for (int j = 0; j < 24; j++) begin
      drv1(j == 0 || j == 8 || j == 16, 100, 0);
      tick();
      ere = (j >= 4 && ((j - 4) % 8) < 4) ? 100 : 0;
      chk_s1("const", j, (j == 4 || j == 12 || j == 20) ? 1 : 0, ere, 0);
    end

    // Full-scale difference rotated by W8^1 saturates the real part
    flush1();
    for (int j = 0; j < 16; j++) begin
      drv1(j == 0 || j == 8, j == 1 ? 32767 : j == 5 ? -32768 : 0,
           j == 1 ? 32767 : j == 5 ? -32768 : 0);
      tick();
      ere = (j == 5) ? -1 : (j == 9) ? 32767 : 0;
      eim = (j == 5) ? -1 : 0;
      chk_s1("sat", j, (j == 4 || j == 12) ? 1 : 0, ere, eim);
    end

    // Last stage: D=1, twiddle bypass, index wraps after 8 outputs
    for (int j = 0; j < 18; j++) begin
      case (j)
        0:       drv3(1'b1, 30000, 0);
        1:       drv3(1'b0, 100, 0);
        2:       drv3(1'b0, -50, 0);
        3:       drv3(1'b0, 21, 0);
        default: drv3(1'b0, 0, 0);
      endcase
      tick();
      case (j)
        1:       ere = 15050;
        2:       ere = 14950;
        3:       ere = -15;
        4:       ere = -36;
        default: ere = 0;
      endcase
      chk($sformatf("last re j%0d", j), int'(bus3.op_re), ere);
      chk($sformatf("last im j%0d", j), int'(bus3.op_im), 0);
      chk($sformatf("last start_op j%0d", j), int'(bus3.start_op), j == 1 ? 1 : 0);
      if (j >= 1) chk($sformatf("last idx j%0d", j), int'(bus3.op_idx), idx_tab[(j - 1) % 8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r2sdf_bf_stage.md
# r2sdf_bf_stage

One pipelined stage of a radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency FFT over 2^N complex points. The stage takes one complex sample per clock, pairs samples D = 2^(N-S) apart in a feedback delay line, and emits sums directly and twiddle-rotated differences D cycles later. N instances chained S = 1..N form the full FFT. The stage also provides a bit-reversed output index (shuffle index) for the downstream natural-order reorder buffer.

## Interface
- N, default 3: log2 of FFT length L = 2^N.
- S, default 1: stage number, 1..N; delay D = 2^(N-S).
- W, default 16: signed data width, real and imaginary.
- TW, default 16: signed twiddle width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start_ip  in  1  high for the first sample of an input frame.
- ip_re, ip_im  in  W  signed input sample, one per cycle, continuous.
- op_re, op_im  out  W  signed registered output sample.
- start_op  out  1  high with the first output of a frame.
- op_idx  out  N  bit-reversed position of the current output within its frame.

## Operation
- Phase counter c, mod 2D. Forced to 0 when start_ip is sampled; otherwise free-runs, so back-to-back frames need no gaps.
- Delay line: D-entry complex shift register. Head = oldest entry.
- Fill phase, c < D:
  - Push the input into the delay line.
  - Output head × twiddle W_L^m, where m = (c)·2^(S-1) and W = cos − j·sin.
  - For S = N the twiddle is exactly 1; bypass the multiplier.
- Butterfly phase, c ≥ D, with a = head and b = input:
  - Output sum = (a+b)>>>1.
  - Push diff = (a−b)>>>1 into the delay line.
  - Sums use W+1-bit intermediates and arithmetic shift, giving 1/2 scaling per stage.
- Twiddle product, with d = head:
  - re = (d_re·cos + d_im·sin + 2^(TW-2)) >>> (TW−1).
  - im = (d_im·cos − d_re·sin + 2^(TW-2)) >>> (TW−1).
  - Saturate each result to W bits.
- Twiddle ROM:
  - L/2 entries, built at elaboration.
  - cos[m] = round(cos(2πm/L)·(2^(TW-1)−1)); sin likewise.
- Shuffle index:
  - Output position counter p, mod L. Set to 0 on the start_op cycle, then increments.
  - op_idx = bit-reverse of p over N bits.
  - For N=3: 0,4,2,6,1,5,3,7.

## Timing
- Input sampled at the rising edge.
- The output for the butterfly-phase input at cycle t appears at t+1 (one register).
- start_ip sampled at cycle t0 → start_op high for exactly one cycle at t0+D+1, together with the sum of x[0] and x[D].
- Frame outputs are continuous for L cycles after start_op.
- Fill-phase outputs of a frame are the rotated differences of the previous butterfly block.
- The first fill phase after reset outputs 0, because the delay line is cleared.
- start_ip mid-frame: counter resyncs to 0, delay contents are kept, and start_op fires at D+1. Outputs of the interrupted frame are undefined but deterministic.
- Reset values: op_re = op_im = 0, start_op = 0, op_idx = 0, c = 0, p = 0, delay line all zero.
- Reset dominates start_ip in the same cycle.

## Test plan
- Reset: hold rst 2 cycles with random inputs → op = 0, start_op = 0, op_idx = 0. Release, drive zero input → op stays 0.
- Latency (N=3, S=1, D=4): start_ip at cycle 0 → start_op only at cycle 5; a repeat frame at cycle 8 gives start_op at cycle 13.
- Impulse (N=3, S=1, W=TW=16): x = {1000,0,0,0,0,0,0,0} → outputs from start_op:
  - re = 500,0,0,0 (sums).
  - then re = 500,0,0,0 (differences, twiddle k=0).
  - all im = 0.
- Twiddle (N=3, S=1): x[1] = 1000, others 0 → position 1 = 500+j0; position 5 = 354 − j354; all others 0.
- Constant input 100+j0, frames back-to-back → sums 100, differences 0, on every frame.
- Last stage (N=3, S=3, D=1): x = {300,100,…} → outputs 200 then 100 (twiddle bypass); op_idx sequence 0,4,2,6,1,5,3,7 and it wraps.
